// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - 3x3 neighbourhood window builder for a raster pixel stream
// Two line buffers feed a 3x3 register window; out_valid marks each complete window.
module window3x3_gen #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [N-1:0] in_pix,
  output logic         out_valid,
  output logic [N-1:0] op1,
  output logic [N-1:0] op2,
  output logic [N-1:0] op3,
  output logic [N-1:0] op4,
  output logic [N-1:0] op5,
  output logic [N-1:0] op6,
  output logic [N-1:0] op7,
  output logic [N-1:0] op8,
  output logic [N-1:0] op9
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ROW0, ROW1, STREAM} row_e;

  row_e              row_q, row_d, row_eff;
  logic [CW-1:0]     col_q, col_d, col_eff;
  logic [AW-1:0]     addr;
  logic [2:0][N-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic              valid_q, valid_d;
  logic [N-1:0]      lb0 [WIDTH];
  logic [N-1:0]      lb1 [WIDTH];
  logic [N-1:0]      lb0_rd, lb1_rd;

  // A start-of-frame beat is treated as (row 0, col 0) whatever state we were in.
  always_comb begin
    col_eff = in_sof ? '0 : col_q;
    row_eff = in_sof ? ROW0 : row_q;
    addr    = col_eff[AW-1:0];
    lb0_rd  = lb0[addr];
    lb1_rd  = lb1[addr];
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    valid_d = 1'b0;
    if (in_valid) begin
      if (col_eff == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_eff == ROW0) ? ROW1 : STREAM;
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
      top_d   = {top_q[1:0], lb1_rd};
      mid_d   = {mid_q[1:0], lb0_rd};
      bot_d   = {bot_q[1:0], in_pix};
      valid_d = (row_eff == STREAM) && (col_eff >= CW'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= ROW0;
      col_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      valid_q <= valid_d;
    end
  end

  // Buffer contents survive reset; stale data never reaches a flagged window.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[addr] <= lb0_rd;
      lb0[addr] <= in_pix;
    end
  end

  assign out_valid = valid_q;
  assign op1 = top_q[2];
  assign op2 = top_q[1];
  assign op3 = top_q[0];
  assign op4 = mid_q[2];
  assign op5 = mid_q[1];
  assign op6 = mid_q[0];
  assign op7 = bot_q[2];
  assign op8 = bot_q[1];
  assign op9 = bot_q[0];

endmodule
